adc_pad_scan_seq: RTL and testbench
===================================

# adc_pad_scan_seq

Scan sequencer for the analog input pad cells (5 V analog-input pads with protection capacitance). It sequences NCH pads onto the shared ADC input node one at a time. For each pad it applies a break-before-make settle gap and a programmable sample window, then issues a conversion request and captures the result. It sits between the register block (START/CHEN/SMPCYC) and the ADC macro, and drives the pad-select and sample switch controls.

## Interface
- NCH, 8: number of analog pad channels (2..16)
- CHW, 3: channel index width, $clog2(NCH)
- DW, 10: ADC result width
- TOUT, 255: conversion timeout in cycles
- CLK  in  1  system clock
- RESETB  in  1  asynchronous active-low reset
- START  in  1  one-cycle scan start pulse
- ABORT  in  1  synchronous abort, highest priority
- CONT  in  1  continuous mode: wrap and rescan until ABORT
- CHEN  in  NCH  channel enable mask, latched at START
- SMPCYC  in  8  sample window length in cycles; 0 treated as 1
- CONVDONE  in  1  ADC conversion complete, one-cycle pulse
- ADDATA  in  DW  ADC data, valid with CONVDONE
- ADSEL  out  NCH  one-hot pad connect enable
- SMPL  out  1  sample switch enable
- CONVREQ  out  1  conversion request, one-cycle pulse
- RESULT  out  DW  last captured result
- RESCH  out  CHW  channel index of RESULT
- RESVLD  out  1  one-cycle result-valid pulse
- BUSY  out  1  high from the cycle after an accepted START until return to IDLE
- ERR  out  1  sticky timeout flag, cleared by next accepted START

## Operation
- All outputs reset to 0. State resets to IDLE, and the channel pointer and latched mask reset to 0.
- States: IDLE, SETTLE, SAMPLE, CONV, STORE.
- IDLE: START with CHEN != 0 is accepted. CHEN is latched, ERR is cleared, the pointer is set to the lowest enabled channel, and the state moves to SETTLE. START with CHEN == 0 is ignored. START while BUSY is ignored.
- SETTLE: 1 cycle with ADSEL = 0 and SMPL = 0 (break-before-make), then SAMPLE.
- SAMPLE: ADSEL[ptr] = 1 and SMPL = 1 for max(SMPCYC,1) cycles. SMPCYC is sampled on SAMPLE entry. The state then moves to CONV, and ADSEL/SMPL drop on the same edge.
- CONV: CONVREQ pulses in the first CONV cycle. The block waits for CONVDONE and counts cycles. If TOUT cycles pass without CONVDONE, it sets ERR and goes to IDLE with no RESVLD.
- STORE: RESULT, RESCH and RESVLD update on the CONVDONE edge. The pointer then advances to the next enabled channel above ptr.
  - If one exists: go to SETTLE.
  - If none and CONT = 1: wrap to the lowest enabled channel and go to SETTLE.
  - Otherwise: go to IDLE.
- ABORT in any state: next edge goes to IDLE with ADSEL, SMPL and CONVREQ at 0. RESULT and ERR are held. A CONVDONE arriving in the same cycle as ABORT is discarded.
- CONVDONE outside CONV is ignored.
- At most one ADSEL bit is ever high. ADSEL and SMPL are never high in SETTLE, CONV or IDLE.

## Timing
- START at edge t: BUSY = 1 and state SETTLE after t. ADSEL/SMPL high after t+1, for SMPCYC cycles.
- CONVREQ is high exactly 1 cycle, in the cycle after SMPL falls.
- CONVDONE sampled at edge c: RESVLD, RESULT and RESCH are valid after c, for one cycle.
- Per-channel period = 1 (settle) + max(SMPCYC,1) + 1 (CONVREQ) + ADC latency + 1 (store) cycles.
- BUSY falls on the edge that enters IDLE. A single-channel, non-CONT scan has BUSY low in the cycle after RESVLD.
- Timeout counter is 8 bits, starts at 0 in the CONVREQ cycle, and ERR is set on the edge where the count reaches TOUT.
- RESETB assertion mid-scan clears all outputs immediately, with no wait for the clock.

## Structure
- Package adc_scan_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, CONV, STORE)
  - default widths
  - TOUT constant
- Sub-module adc_scan_next_ch: combinational priority finder. Given mask and ptr, it returns the next enabled index above ptr, the lowest enabled index, and a found flag. It is used at START and at STORE.
- Top holds the FSM, sample/timeout counters and the result registers.

## Test plan
- Single channel, SMPCYC = 4, CHEN = 8'h04, CONVDONE 3 cycles after CONVREQ with ADDATA = 10'h2A5. Expect:
  - ADSEL = 8'h04 for 4 cycles
  - one CONVREQ pulse
  - RESULT = 10'h2A5, RESCH = 2, one RESVLD
  - BUSY low one cycle later
- CHEN = 8'hA1, non-CONT: channels 0, 5, 7 in order, each preceded by a 1-cycle all-zero ADSEL gap; exactly three RESVLD; then IDLE.
- CONT = 1, CHEN = 8'h81: order 0, 7, 0, 7…. ABORT during SAMPLE of ch 7 → ADSEL = 0 next cycle, BUSY = 0, no further CONVREQ.
- SMPCYC = 0 → 1-cycle sample window. START with CHEN = 0 → BUSY stays 0. START while BUSY → ignored, sequence unchanged.
- Withhold CONVDONE → ERR = 1 after 255 CONV cycles, IDLE, no RESVLD. Next START clears ERR.
- RESETB low during CONV → all outputs 0 asynchronously. After release, CONVDONE is ignored until a new START.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared types, default widths and timing constants for the analog pad scan sequencer.
package adc_scan_pkg;

  localparam int unsigned DEF_NCH  = 8;
  localparam int unsigned DEF_DW   = 10;
  localparam int unsigned DEF_TOUT = 255;
  localparam int unsigned CNTW     = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    CONV   = 3'd3,
    STORE  = 3'd4
  } scan_state_e;

  // Terminal count for a down-counting sample window; a zero length behaves as one cycle.
  function automatic logic [CNTW-1:0] smp_last(input logic [CNTW-1:0] smpcyc);
    return (smpcyc == '0) ? '0 : smpcyc - CNTW'(1);
  endfunction

endpackage

// File: rtl/adc_scan_next_ch.sv
// Priority finder over the channel enable mask: next enabled index above ptr and lowest enabled index.
module adc_scan_next_ch #(
  parameter int unsigned NCH = 8,
  parameter int unsigned CHW = 3
) (
  input  logic [NCH-1:0] mask,
  input  logic [CHW-1:0] ptr,
  output logic [CHW-1:0] nxt_idx_c,
  output logic [CHW-1:0] low_idx_c,
  output logic           nxt_found_c
);

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    nxt_idx_c   = '0;
    low_idx_c   = '0;
    nxt_found_c = 1'b0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx_c = CHW'(i);
        if (CHW'(i) > ptr) begin
          nxt_idx_c   = CHW'(i);
          nxt_found_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_pad_scan_seq.sv
// Scan sequencer: connects enabled analog pads to the shared ADC node one at a time,
// with a break-before-make gap, a programmable sample window and timed-out conversions.
module adc_pad_scan_seq
  import adc_scan_pkg::*;
#(
  parameter int unsigned NCH  = DEF_NCH,
  parameter int unsigned CHW  = $clog2(NCH),
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned TOUT = DEF_TOUT
) (
  input  logic           clk,
  input  logic           resetb,
  input  logic           start,
  input  logic           abort,
  input  logic           cont,
  input  logic [NCH-1:0] chen,
  input  logic [7:0]     smpcyc,
  input  logic           convdone,
  input  logic [DW-1:0]  addata,
  output logic [NCH-1:0] adsel,
  output logic           smpl,
  output logic           convreq,
  output logic [DW-1:0]  result,
  output logic [CHW-1:0] resch,
  output logic           resvld,
  output logic           busy,
  output logic           err
);

  scan_state_e     state_q, state_d;
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [CNTW-1:0] scnt_q, scnt_d;
  logic [CNTW-1:0] tcnt_q, tcnt_d;

  logic [NCH-1:0]  adsel_d;
  logic            smpl_d;
  logic            convreq_d;
  logic [DW-1:0]   result_d;
  logic [CHW-1:0]  resch_d;
  logic            resvld_d;
  logic            busy_d;
  logic            err_d;

  logic [NCH-1:0]  fmask;
  logic [CHW-1:0]  nxt_idx_c;
  logic [CHW-1:0]  low_idx_c;
  logic            nxt_found_c;

  // In IDLE the finder looks at the live mask for START; otherwise at the latched scan mask.
  assign fmask = (state_q == IDLE) ? chen : mask_q;

  adc_scan_next_ch #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_next_ch (
    .mask        (fmask),
    .ptr         (ptr_q),
    .nxt_idx_c   (nxt_idx_c),
    .low_idx_c   (low_idx_c),
    .nxt_found_c (nxt_found_c)
  );

  // Next-state, counters and result capture; ABORT overrides everything.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    scnt_d   = scnt_q;
    tcnt_d   = tcnt_q;
    result_d = result;
    resch_d  = resch;
    err_d    = err;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (chen != '0)) begin
            state_d = SETTLE;
            mask_d  = chen;
            ptr_d   = low_idx_c;
            err_d   = 1'b0;
          end
        end
        SETTLE: begin
          state_d = SAMPLE;
          scnt_d  = smp_last(smpcyc);
        end
        SAMPLE: begin
          if (scnt_q == '0) begin
            state_d = CONV;
            tcnt_d  = '0;
          end else begin
            scnt_d = scnt_q - CNTW'(1);
          end
        end
        CONV: begin
          if (convdone) begin
            state_d  = STORE;
            result_d = addata;
            resch_d  = ptr_q;
          end else if (tcnt_q == CNTW'(TOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + CNTW'(1);
          end
        end
        STORE: begin
          if (nxt_found_c) begin
            state_d = SETTLE;
            ptr_d   = nxt_idx_c;
          end else if (cont) begin
            state_d = SETTLE;
            ptr_d   = low_idx_c;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pad controls are decoded from the upcoming state so they switch on the state edge.
  always_comb begin
    adsel_d   = '0;
    smpl_d    = 1'b0;
    convreq_d = 1'b0;
    resvld_d  = 1'b0;
    busy_d    = 1'b0;
    if (state_d == SAMPLE) begin
      adsel_d = NCH'(1) << ptr_d;
      smpl_d  = 1'b1;
    end
    convreq_d = (state_d == CONV) && (state_q != CONV);
    resvld_d  = (state_d == STORE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      adsel   <= '0;
      smpl    <= 1'b0;
      convreq <= 1'b0;
      result  <= '0;
      resch   <= '0;
      resvld  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      adsel   <= adsel_d;
      smpl    <= smpl_d;
      convreq <= convreq_d;
      result  <= result_d;
      resch   <= resch_d;
      resvld  <= resvld_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_adc_pad_scan_seq.sv
// Scoreboard bench for adc_pad_scan_seq with a behavioural ADC responder and an output monitor.
module tb_adc_pad_scan_seq;

  localparam int unsigned NCH  = 8;
  localparam int unsigned CHW  = 3;
  localparam int unsigned DW   = 10;
  localparam int          TOUT = 255;

  logic           clk = 1'b0;
  logic           resetb;
  logic           start;
  logic           abort;
  logic           cont;
  logic [NCH-1:0] chen;
  logic [7:0]     smpcyc;
  logic           convdone;
  logic [DW-1:0]  addata;
  logic [NCH-1:0] adsel;
  logic           smpl;
  logic           convreq;
  logic [DW-1:0]  result;
  logic [CHW-1:0] resch;
  logic           resvld;
  logic           busy;
  logic           err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int             adc_lat = 3;
  bit             adc_en  = 1'b1;
  int             cd      = 0;
  logic [DW-1:0]  adc_q[$];
  logic [CHW+DW-1:0] exp_q[$];
  logic [CHW+DW-1:0] sb_e;

  int order_q[$];
  int rise_q[$];
  int win_q[$];
  int n_convreq = 0;
  int n_resvld  = 0;
  int run       = 0;
  logic [NCH-1:0] prev_adsel = '0;

  adc_pad_scan_seq dut (
    .clk      (clk),
    .resetb   (resetb),
    .start    (start),
    .abort    (abort),
    .cont     (cont),
    .chen     (chen),
    .smpcyc   (smpcyc),
    .convdone (convdone),
    .addata   (addata),
    .adsel    (adsel),
    .smpl     (smpl),
    .convreq  (convreq),
    .result   (result),
    .resch    (resch),
    .resvld   (resvld),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    int r = -1;
    for (int i = 0; i < int'(NCH); i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q_str(input int a[$]);
    string s = "";
    foreach (a[i]) s = {s, $sformatf("%0d ", a[i])};
    return s;
  endfunction

  // ADC model: converts after adc_lat cycles, data from adc_q.
  initial begin
    convdone = 1'b0;
    addata   = '0;
    forever begin
      @(negedge clk);
      convdone = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          convdone = 1'b1;
          addata   = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
        end
      end
      if (convreq && adc_en) cd = adc_lat;
    end
  end

  // Monitor: pad-switch invariants, activity logs and result scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (resetb) begin
        checks++;
        if (($countones(adsel) > 1) || ((adsel != '0) != smpl)) begin
          errors++;
          $display("FAIL adsel_invariant adsel=%h smpl=%b cycle=%0d", adsel, smpl, cyc);
        end
        if (convreq) n_convreq++;
        if ((adsel != '0) && (prev_adsel == '0)) begin
          order_q.push_back(onehot_idx(adsel));
          rise_q.push_back(cyc);
        end
        if (adsel != '0) run++;
        else if (run > 0) begin
          win_q.push_back(run);
          run = 0;
        end
        if (resvld) begin
          n_resvld++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resvld_unexpected got ch=%0d data=%h required no result", resch, result);
          end else begin
            sb_e = exp_q.pop_front();
            if ({resch, result} !== sb_e) begin
              errors++;
              $display("FAIL result got ch=%0d data=%h required ch=%0d data=%h",
                       resch, result, sb_e[CHW+DW-1:DW], sb_e[DW-1:0]);
            end
          end
        end
      end
      prev_adsel = adsel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    order_q.delete();
    rise_q.delete();
    win_q.delete();
    exp_q.delete();
    adc_q.delete();
    n_convreq = 0;
    n_resvld  = 0;
    run       = 0;
    cd        = 0;
  endtask

  task automatic pulse_start(input logic [NCH-1:0] m);
    @(negedge clk);
    chen  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input int budget, output int rv_k, output int idle_k, output bit to);
    rv_k   = -1;
    idle_k = -1;
    to     = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (resvld) rv_k = k;
      if (!busy) begin
        idle_k = k;
        to     = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
    chen = '0; smpcyc = 8'd1;
    repeat (2) @(negedge clk);
    checks++;
    if ({adsel, smpl, convreq, result, resch, resvld, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got adsel=%h smpl=%b convreq=%b result=%h resch=%0d resvld=%b busy=%b err=%b required all 0",
               adsel, smpl, convreq, result, resch, resvld, busy, err);
    end
    resetb = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b required 0", busy); end
  endtask

  task automatic test_single();
    int rv_k, idle_k; bit to; int eo[$];
    clear_logs();
    smpcyc = 8'd4; cont = 1'b0; adc_lat = 3;
    adc_q.push_back(10'h2A5);
    exp_q.push_back({3'd2, 10'h2A5});
    pulse_start(8'h04);
    checks++;
    if (busy !== 1'b1 || adsel !== '0) begin
      errors++; $display("FAIL single_settle got busy=%b adsel=%h required busy=1 adsel=00", busy, adsel);
    end
    run_scan(60, rv_k, idle_k, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout got busy=%b required idle within 60 cycles", busy); end
    eo.push_back(2);
    checks++;
    if (!q_eq(order_q, eo)) begin errors++; $display("FAIL single_order got %s required 2", q_str(order_q)); end
    eo.delete(); eo.push_back(4);
    checks++;
    if (!q_eq(win_q, eo)) begin errors++; $display("FAIL single_window got %s required 4", q_str(win_q)); end
    checks++;
    if (n_convreq != 1) begin errors++; $display("FAIL single_convreq got %0d required 1", n_convreq); end
    checks++;
    if (n_resvld != 1) begin errors++; $display("FAIL single_resvld got %0d required 1", n_resvld); end
    checks++;
    if (idle_k - rv_k != 1) begin errors++; $display("FAIL single_busy_fall got %0d required 1", idle_k - rv_k); end
    checks++;
    if (result !== 10'h2A5 || resch !== 3'd2) begin
      errors++; $display("FAIL single_held got ch=%0d data=%h required ch=2 data=2a5", resch, result);
    end
  endtask

  task automatic test_multi();
    int rv_k, idle_k; bit to; int eo[$];
    clear_logs();
    smpcyc = 8'd2; cont = 1'b0; adc_lat = 2;
    adc_q.push_back(10'h101); exp_q.push_back({3'd0, 10'h101});
    adc_q.push_back(10'h155); exp_q.push_back({3'd5, 10'h155});
    adc_q.push_back(10'h3FF); exp_q.push_back({3'd7, 10'h3FF});
    pulse_start(8'hA1);
    run_scan(120, rv_k, idle_k, to);
    checks++;
    if (to) begin errors++; $display("FAIL multi_timeout got busy=%b required idle", busy); end
    eo.push_back(0); eo.push_back(5); eo.push_back(7);
    checks++;
    if (!q_eq(order_q, eo)) begin errors++; $display("FAIL multi_order got %s required 0 5 7", q_str(order_q)); end
    eo.delete(); eo.push_back(2); eo.push_back(2); eo.push_back(2);
    checks++;
    if (!q_eq(win_q, eo)) begin errors++; $display("FAIL multi_window got %s required 2 2 2", q_str(win_q)); end
    checks++;
    if (n_resvld != 3) begin errors++; $display("FAIL multi_resvld got %0d required 3", n_resvld); end
    for (int i = 1; i < rise_q.size(); i++) begin
      checks++;
      if (rise_q[i] - rise_q[i-1] != 7) begin
        errors++; $display("FAIL multi_period got %0d required 7", rise_q[i] - rise_q[i-1]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL multi_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_cont_abort();
    int rises; bit hit; int eo[$]; logic [NCH-1:0] pv;
    clear_logs();
    smpcyc = 8'd3; cont = 1'b1; adc_lat = 1;
    adc_q.push_back(10'h011); exp_q.push_back({3'd0, 10'h011});
    adc_q.push_back(10'h022); exp_q.push_back({3'd7, 10'h022});
    adc_q.push_back(10'h033); exp_q.push_back({3'd0, 10'h033});
    pulse_start(8'h81);
    rises = 0; hit = 1'b0; pv = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (adsel == 8'h80 && pv != 8'h80) rises++;
      pv = adsel;
      if (rises == 2) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    cont = 1'b0;
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach got rises=%0d required 2", rises); end
    checks++;
    if (adsel !== '0 || smpl !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state got adsel=%h smpl=%b busy=%b required 0 0 0", adsel, smpl, busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (n_convreq != 3) begin errors++; $display("FAIL abort_convreq got %0d required 3", n_convreq); end
    checks++;
    if (n_resvld != 3) begin errors++; $display("FAIL abort_resvld got %0d required 3", n_resvld); end
    eo.push_back(0); eo.push_back(7); eo.push_back(0); eo.push_back(7);
    checks++;
    if (!q_eq(order_q, eo)) begin errors++; $display("FAIL cont_order got %s required 0 7 0 7", q_str(order_q)); end
    checks++;
    if (result !== 10'h033 || resch !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_hold got ch=%0d data=%h busy=%b required ch=0 data=033 busy=0", resch, result, busy);
    end
  endtask

  task automatic test_smp0_ignore();
    int rv_k, idle_k; bit to; int eo[$]; int bhi;
    clear_logs();
    smpcyc = 8'd0; cont = 1'b0; adc_lat = 2;
    adc_q.push_back(10'h0AA); exp_q.push_back({3'd1, 10'h0AA});
    pulse_start(8'h02);
    @(negedge clk);
    chen = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_scan(60, rv_k, idle_k, to);
    checks++;
    if (to) begin errors++; $display("FAIL smp0_timeout got busy=%b required idle", busy); end
    eo.push_back(1);
    checks++;
    if (!q_eq(order_q, eo)) begin errors++; $display("FAIL busy_start_order got %s required 1", q_str(order_q)); end
    checks++;
    if (!q_eq(win_q, eo)) begin errors++; $display("FAIL smp0_window got %s required 1", q_str(win_q)); end
    checks++;
    if (n_resvld != 1 || n_convreq != 1) begin
      errors++; $display("FAIL busy_start_counts got resvld=%0d convreq=%0d required 1 1", n_resvld, n_convreq);
    end
    pulse_start(8'h00);
    bhi = busy ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) bhi++;
    end
    checks++;
    if (bhi != 0) begin errors++; $display("FAIL chen0_busy got %0d busy cycles required 0", bhi); end
  endtask

  task automatic test_timeout();
    int cr_k, er_k, rv_k, idle_k; bit to;
    clear_logs();
    smpcyc = 8'd1; cont = 1'b0; adc_en = 1'b0;
    pulse_start(8'h10);
    cr_k = -1; er_k = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (convreq) cr_k = k;
      if (err) begin er_k = k; break; end
    end
    checks++;
    if (er_k < 0 || cr_k < 0) begin
      errors++; $display("FAIL timeout_seen got err=%b convreq_seen=%0d required err=1", err, cr_k);
    end
    checks++;
    if (er_k - cr_k != TOUT) begin errors++; $display("FAIL timeout_len got %0d required %0d", er_k - cr_k, TOUT); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got busy=%b required 0", busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || n_resvld != 0) begin
      errors++; $display("FAIL timeout_sticky got err=%b resvld=%0d required 1 0", err, n_resvld);
    end
    adc_en = 1'b1; adc_lat = 2;
    adc_q.push_back(10'h123); exp_q.push_back({3'd0, 10'h123});
    pulse_start(8'h01);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL err_clear got err=%b busy=%b required 0 1", err, busy);
    end
    run_scan(60, rv_k, idle_k, to);
    checks++;
    if (to || n_resvld != 1) begin
      errors++; $display("FAIL after_timeout_scan got resvld=%0d busy=%b required 1 0", n_resvld, busy);
    end
  endtask

  task automatic test_reset_midscan();
    bit seen;
    clear_logs();
    smpcyc = 8'd2; cont = 1'b0; adc_lat = 5;
    adc_q.push_back(10'h1C3);
    pulse_start(8'h08);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (convreq) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b1) begin
      errors++; $display("FAIL midscan_conv got convreq_seen=%b busy=%b required 1 1", seen, busy);
    end
    #1 resetb = 1'b0;
    #1;
    checks++;
    if ({adsel, smpl, convreq, result, resch, resvld, busy, err} !== '0) begin
      errors++; $display("FAIL async_reset got adsel=%h smpl=%b convreq=%b result=%h resch=%0d resvld=%b busy=%b err=%b required all 0",
                         adsel, smpl, convreq, result, resch, resvld, busy, err);
    end
    @(negedge clk);
    resetb = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (n_resvld != 0 || busy !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL post_reset_convdone got resvld=%0d busy=%b result=%h required 0 0 000", n_resvld, busy, result);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    repeat (5) @(negedge clk);
    test_multi();
    repeat (5) @(negedge clk);
    test_cont_abort();
    test_smp0_ignore();
    repeat (5) @(negedge clk);
    test_timeout();
    repeat (8) @(negedge clk);
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
